// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron datapath: sizing constants, the backprop
// FSM state type and the sigmoid derivative used by both directions.
package neuron_pkg;

  localparam int N_INPUTS_DEFAULT = 32;
  localparam int BIAS_IDX         = N_INPUTS_DEFAULT;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DELTA = 3'd1,
    SCAN  = 3'd2,
    BIAS  = 3'd3,
    DONE  = 3'd4
  } bp_state_t;

  // Sigmoid derivative expressed through the sigmoid output itself.
  function automatic real sigmoid_deriv(input real a);
    return a * (1.0 - a);
  endfunction

endpackage

// File: rtl/neuron_backprop_if.sv
// Request/response bundle between a training sequencer (master) and one
// neuron_backprop instance (slave).
interface neuron_backprop_if
  import neuron_pkg::*;
#(
  parameter int N_INPUTS = N_INPUTS_DEFAULT
);

  logic                start;
  real                 axon_err;
  real                 axon;
  real                 learn_rate;
  real                 dendrites    [N_INPUTS-1:0];
  real                 weights_in   [N_INPUTS:0];
  logic [N_INPUTS-1:0] enabled;
  real                 weights_out  [N_INPUTS:0];
  real                 dendrite_err [N_INPUTS-1:0];
  logic                busy;
  logic                done;

  modport master (
    output start, axon_err, axon, learn_rate, dendrites, weights_in, enabled,
    input  weights_out, dendrite_err, busy, done
  );

  modport slave (
    input  start, axon_err, axon, learn_rate, dendrites, weights_in, enabled,
    output weights_out, dendrite_err, busy, done
  );

endinterface

// File: rtl/bp_lane.sv
// Per-dendrite backprop arithmetic: gradient-step weight update and the
// error propagated upstream, both derived from the pre-update weight.
module bp_lane (
  input  real  w,
  input  real  d,
  input  logic en,
  input  real  delta,
  input  real  step,
  output real  w_new,
  output real  err_back
);

  // Disabled dendrites pass their weight through and send no error back.
  always_comb begin
    if (en) begin
      w_new    = w + step * d;
      err_back = delta * w;
    end else begin
      w_new    = w;
      err_back = 0.0;
    end
  end

endmodule

// File: rtl/neuron_backprop.sv
// Serial backprop for one neuron: one dendrite per clock through a single
// shared bp_lane, then the bias, then a one-cycle done pulse.
module neuron_backprop
  import neuron_pkg::*;
#(
  parameter int N_INPUTS = N_INPUTS_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  neuron_backprop_if.slave  bus
);

  localparam int SW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int IW = $clog2(N_INPUTS + 1);
  localparam logic [SW-1:0] LAST_IDX = SW'(N_INPUTS - 1);

  bp_state_t           state_r;
  bp_state_t           state_nxt_s;
  logic [SW-1:0]       index_r;
  real                 axon_err_r;
  real                 axon_r;
  real                 learn_rate_r;
  real                 d_r [N_INPUTS-1:0];
  real                 w_r [N_INPUTS-1:0];
  real                 wb_r;
  logic [N_INPUTS-1:0] en_r;
  real                 delta_r;
  real                 step_r;
  real                 delta_s;
  real                 lane_w_new_s;
  real                 lane_err_s;

  assign delta_s = axon_err_r * sigmoid_deriv(axon_r);

  bp_lane u_lane (
    .w        (w_r[index_r]),
    .d        (d_r[index_r]),
    .en       (en_r[index_r]),
    .delta    (delta_r),
    .step     (step_r),
    .w_new    (lane_w_new_s),
    .err_back (lane_err_s)
  );

  // Next-state logic for the IDLE -> DELTA -> SCAN -> BIAS -> DONE sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_nxt_s = DELTA;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DELTA: state_nxt_s = SCAN;
      SCAN: begin
        if (index_r == LAST_IDX) begin
          state_nxt_s = BIAS;
        end else begin
          state_nxt_s = SCAN;
        end
      end
      BIAS:    state_nxt_s = DONE;
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, operand capture and output registers; busy/done follow the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      index_r      <= '0;
      axon_err_r   <= 0.0;
      axon_r       <= 0.0;
      learn_rate_r <= 0.0;
      wb_r         <= 0.0;
      en_r         <= '0;
      delta_r      <= 0.0;
      step_r       <= 0.0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      for (int i = 0; i < N_INPUTS; i++) begin
        d_r[i]              <= 0.0;
        w_r[i]              <= 0.0;
        bus.weights_out[i]  <= 0.0;
        bus.dendrite_err[i] <= 0.0;
      end
      bus.weights_out[N_INPUTS] <= 0.0;
    end else begin
      state_r  <= state_nxt_s;
      bus.busy <= (state_nxt_s != IDLE);
      bus.done <= (state_nxt_s == DONE);
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            axon_err_r   <= bus.axon_err;
            axon_r       <= bus.axon;
            learn_rate_r <= bus.learn_rate;
            en_r         <= bus.enabled;
            wb_r         <= bus.weights_in[N_INPUTS];
            for (int i = 0; i < N_INPUTS; i++) begin
              d_r[i] <= bus.dendrites[i];
              w_r[i] <= bus.weights_in[i];
            end
          end
        end
        DELTA: begin
          delta_r <= delta_s;
          step_r  <= learn_rate_r * delta_s;
          index_r <= '0;
        end
        SCAN: begin
          bus.weights_out[IW'(index_r)] <= lane_w_new_s;
          bus.dendrite_err[index_r]     <= lane_err_s;
          // Hold at the last index so the lane select never leaves range.
          if (index_r != LAST_IDX) begin
            index_r <= index_r + SW'(1);
          end
        end
        BIAS: begin
          bus.weights_out[N_INPUTS] <= wb_r + step_r;
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule
